decode_family: RTL and testbench

DECODE_FAMILY -- requirements
Module: decode_family

---
 rtl/decode_family_pkg.sv | 60 ++++++
 rtl/decode_family_match.sv | 17 +
 rtl/decode_family.sv | 70 +++++++
 tb/tb_decode_family.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/decode_family_pkg.sv
// Shared constants for the ARMv4 instruction family decoder: family indices,
// per-family mask/match pairs and the priority order used by DECODE_PRIO_EN.
package decode_family_pkg;

  localparam int unsigned NUM_FAM = 16;

  localparam logic [3:0] FAM_DP_IMM  = 4'd0;
  localparam logic [3:0] FAM_DP_ISH  = 4'd1;
  localparam logic [3:0] FAM_DP_RSH  = 4'd2;
  localparam logic [3:0] FAM_MUL     = 4'd3;
  localparam logic [3:0] FAM_MULL    = 4'd4;
  localparam logic [3:0] FAM_MRS     = 4'd5;
  localparam logic [3:0] FAM_MSR_IMM = 4'd6;
  localparam logic [3:0] FAM_MSR_REG = 4'd7;
  localparam logic [3:0] FAM_LS_IMM  = 4'd8;
  localparam logic [3:0] FAM_LS_REG  = 4'd9;
  localparam logic [3:0] FAM_HW_IMM  = 4'd10;
  localparam logic [3:0] FAM_HW_REG  = 4'd11;
  localparam logic [3:0] FAM_SWP     = 4'd12;
  localparam logic [3:0] FAM_LSM     = 4'd13;
  localparam logic [3:0] FAM_BR      = 4'd14;
  localparam logic [3:0] FAM_UNDEF   = 4'd15;

  // A word belongs to family i when (ir & FAM_MASK[i]) == FAM_MATCH[i].
  localparam logic [31:0] FAM_MASK [0:15] = '{
    32'h0E00_0000, 32'h0E00_0010, 32'h0E00_0090, 32'h0FC0_00F0,
    32'h0F80_00F0, 32'h0FB0_0000, 32'h0FB0_0000, 32'h0FB0_0010,
    32'h0E00_0000, 32'h0E00_0010, 32'h0E40_0090, 32'h0E40_0090,
    32'h0FB0_00F0, 32'h0E00_0000, 32'h0E00_0000, 32'h0E00_0010
  };

  localparam logic [31:0] FAM_MATCH [0:15] = '{
    32'h0200_0000, 32'h0000_0000, 32'h0000_0010, 32'h0000_0090,
    32'h0080_0090, 32'h0100_0000, 32'h0320_0000, 32'h0120_0000,
    32'h0400_0000, 32'h0600_0000, 32'h0040_0090, 32'h0000_0090,
    32'h0100_0090, 32'h0800_0000, 32'h0A00_0000, 32'h0600_0010
  };

  // Highest priority first.
  localparam logic [3:0] PRIO_ORDER [0:15] = '{
    FAM_SWP, FAM_MUL, FAM_MULL, FAM_HW_IMM, FAM_HW_REG, FAM_MRS,
    FAM_MSR_REG, FAM_MSR_IMM, FAM_UNDEF, FAM_LS_REG, FAM_LS_IMM,
    FAM_LSM, FAM_BR, FAM_DP_RSH, FAM_DP_ISH, FAM_DP_IMM
  };

  // Returns {hit, idx}; walks lowest priority first so the highest set bit wins.
  function automatic logic [4:0] prio_pick(input logic [15:0] fam);
    logic [4:0] res;
    res = 5'd0;
    for (int k = 15; k >= 0; k--) begin
      if (fam[PRIO_ORDER[k]]) begin
        res = {1'b1, PRIO_ORDER[k]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/decode_family_match.sv
// Purely combinational family matcher: one independent mask/match test per family.
module decode_family_match
  import decode_family_pkg::*;
(
  input  logic [31:0] ir,
  output logic [15:0] f
);

  // Evaluate every family pattern in parallel; overlaps give a multi-hot result.
  always_comb begin
    f = 16'h0000;
    for (int i = 0; i < NUM_FAM; i++) begin
      f[i] = ((ir & FAM_MASK[i]) == FAM_MATCH[i]);
    end
  end

endmodule

// File: rtl/decode_family.sv
// ARMv4 instruction family decoder with one-cycle registered outputs.
// Optional macro DECODE_PRIO_EN adds fam_hit/fam_idx priority-encoded outputs.
module decode_family
  import decode_family_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_valid,
  input  logic [31:0] ir,
  output logic        f_valid,
  output logic [15:0] f
`ifdef DECODE_PRIO_EN
  , output logic      fam_hit
  , output logic [3:0] fam_idx
`endif
);

  logic [15:0] f_s;
  logic [15:0] f_r;
  logic        f_valid_r;

  decode_family_match u_match (
    .ir (ir),
    .f  (f_s)
  );

  // Capture the match vector on valid words; f holds when ir_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_r       <= 16'h0000;
      f_valid_r <= 1'b0;
    end else begin
      f_valid_r <= ir_valid;
      if (ir_valid) begin
        f_r <= f_s;
      end else begin
        f_r <= f_r;
      end
    end
  end

  assign f       = f_r;
  assign f_valid = f_valid_r;

`ifdef DECODE_PRIO_EN
  logic [4:0] prio_s;
  logic       fam_hit_r;
  logic [3:0] fam_idx_r;

  assign prio_s = prio_pick(f_s);

  // Priority result registered alongside f so both update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      fam_hit_r <= 1'b0;
      fam_idx_r <= 4'd0;
    end else if (ir_valid) begin
      fam_hit_r <= prio_s[4];
      fam_idx_r <= prio_s[3:0];
    end else begin
      fam_hit_r <= fam_hit_r;
      fam_idx_r <= fam_idx_r;
    end
  end

  assign fam_hit = fam_hit_r;
  assign fam_idx = fam_idx_r;
`endif

endmodule

// File: tb/tb_decode_family.sv
// Self-checking bench for decode_family: directed vector table, reset/hold
// sequences, then random words checked against a pattern-string reference model.
module tb_decode_family;

  logic        clk;
  logic        rst;
  logic        ir_valid;
  logic [31:0] ir;
  logic        f_valid;
  logic [15:0] f;
`ifdef DECODE_PRIO_EN
  logic        fam_hit;
  logic [3:0]  fam_idx;
`endif

  int n_total;
  int n_pass;

  decode_family dut (
    .clk      (clk),
    .rst      (rst),
    .ir_valid (ir_valid),
    .ir       (ir),
    .f_valid  (f_valid),
    .f        (f)
`ifdef DECODE_PRIO_EN
    , .fam_hit (fam_hit)
    , .fam_idx (fam_idx)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Family patterns exactly as written in the instruction-set table, bit 31 first.
  string pat [16] = '{
    "xxxx 001x xxxx xxxx xxxx xxxx xxxx xxxx",
    "xxxx 000x xxxx xxxx xxxx xxxx xxx0 xxxx",
    "xxxx 000x xxxx xxxx xxxx xxxx 0xx1 xxxx",
    "xxxx 0000 00xx xxxx xxxx xxxx 1001 xxxx",
    "xxxx 0000 1xxx xxxx xxxx xxxx 1001 xxxx",
    "xxxx 0001 0x00 xxxx xxxx xxxx xxxx xxxx",
    "xxxx 0011 0x10 xxxx xxxx xxxx xxxx xxxx",
    "xxxx 0001 0x10 xxxx xxxx xxxx xxx0 xxxx",
    "xxxx 010x xxxx xxxx xxxx xxxx xxxx xxxx",
    "xxxx 011x xxxx xxxx xxxx xxxx xxx0 xxxx",
    "xxxx 000x x1xx xxxx xxxx xxxx 1xx1 xxxx",
    "xxxx 000x x0xx xxxx xxxx xxxx 1xx1 xxxx",
    "xxxx 0001 0x00 xxxx xxxx xxxx 1001 xxxx",
    "xxxx 100x xxxx xxxx xxxx xxxx xxxx xxxx",
    "xxxx 101x xxxx xxxx xxxx xxxx xxxx xxxx",
    "xxxx 011x xxxx xxxx xxxx xxxx xxx1 xxxx"
  };

  int prio [16] = '{12, 3, 4, 10, 11, 5, 7, 6, 15, 9, 8, 13, 14, 2, 1, 0};

  function automatic logic [15:0] model_f(input logic [31:0] w);
    logic [15:0] r;
    r = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      int  b;
      bit  ok;
      byte ch;
      b  = 31;
      ok = 1'b1;
      for (int c = 0; c < pat[i].len(); c++) begin
        ch = pat[i][c];
        if (ch != " ") begin
          if (ch == "0" && w[b] != 1'b0) ok = 1'b0;
          if (ch == "1" && w[b] != 1'b1) ok = 1'b0;
          b = b - 1;
        end
      end
      r[i] = ok;
    end
    return r;
  endfunction

  function automatic logic [3:0] model_idx(input logic [15:0] fv);
    for (int k = 0; k < 16; k++) begin
      if (fv[prio[k]]) return 4'(prio[k]);
    end
    return 4'd0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle from the falling edge, then sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic v, input logic [31:0] w);
    @(negedge clk);
    rst      = r;
    ir_valid = v;
    ir       = w;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [15:0] ef, input logic ev);
    check({tag, ".f"}, {16'h0000, f}, {16'h0000, ef});
    check({tag, ".f_valid"}, {31'd0, f_valid}, {31'd0, ev});
`ifdef DECODE_PRIO_EN
    check({tag, ".fam_hit"}, {31'd0, fam_hit}, {31'd0, (ef != 16'h0000)});
    check({tag, ".fam_idx"}, {28'd0, fam_idx}, {28'd0, model_idx(ef)});
`endif
  endtask

  typedef struct {
    logic [31:0] w;
    logic [15:0] ef;
    logic [3:0]  eidx;
  } vec_t;

  vec_t vecs [12];

  initial begin
    logic [15:0] exp_f;
    logic        exp_v;
    n_total  = 0;
    n_pass   = 0;
    rst      = 1'b1;
    ir_valid = 1'b0;
    ir       = 32'h0000_0000;

    vecs[0]  = '{32'h0200_0000, 16'h0001, 4'd0};
    vecs[1]  = '{32'h0000_0000, 16'h0002, 4'd1};
    vecs[2]  = '{32'h0000_0090, 16'h0808, 4'd3};
    vecs[3]  = '{32'h0100_0090, 16'h1820, 4'd12};
    vecs[4]  = '{32'h0600_0010, 16'h8000, 4'd15};
    vecs[5]  = '{32'h0A00_0000, 16'h4000, 4'd14};
    vecs[6]  = '{32'hF400_0000, 16'h0100, 4'd8};
    vecs[7]  = '{32'h0C00_0000, 16'h0000, 4'd0};
    vecs[8]  = '{32'h0320_0000, 16'h0041, 4'd6};
    vecs[9]  = '{32'h0120_0000, 16'h0082, 4'd7};
    vecs[10] = '{32'h0080_0090, 16'h0810, 4'd4};
    vecs[11] = '{32'h0040_0090, 16'h0400, 4'd10};

    step(1'b1, 1'b0, 32'h0000_0000);
    step(1'b1, 1'b0, 32'h0000_0000);
    check_all("reset", 16'h0000, 1'b0);

    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b1, vecs[i].w);
      check($sformatf("vec%0d.f", i), {16'h0000, f}, {16'h0000, vecs[i].ef});
      check($sformatf("vec%0d.f_valid", i), {31'd0, f_valid}, 32'd1);
`ifdef DECODE_PRIO_EN
      check($sformatf("vec%0d.fam_hit", i), {31'd0, fam_hit}, {31'd0, (vecs[i].ef != 16'h0000)});
      check($sformatf("vec%0d.fam_idx", i), {28'd0, fam_idx}, {28'd0, vecs[i].eidx});
`endif
    end

    // Hold: f keeps the last word's result while f_valid drops.
    step(1'b0, 1'b1, 32'h0100_0090);
    step(1'b0, 1'b0, 32'h0200_0000);
    check_all("hold", 16'h1820, 1'b0);
    step(1'b0, 1'b0, 32'h0A00_0000);
    check_all("hold2", 16'h1820, 1'b0);

    // Reset beats a simultaneous valid word.
    step(1'b1, 1'b1, 32'h0200_0000);
    check_all("rst_vs_valid", 16'h0000, 1'b0);

    // Back-to-back words, one per cycle.
    step(1'b0, 1'b1, 32'h0A00_0000);
    check_all("b2b0", 16'h4000, 1'b1);
    step(1'b0, 1'b1, 32'h0000_0090);
    check_all("b2b1", 16'h0808, 1'b1);

    exp_f = 16'h0808;
    exp_v = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic        v;
      logic [31:0] w;
      r = ($urandom_range(0, 19) == 0);
      v = ($urandom_range(0, 3) != 0);
      w = $urandom;
      step(r, v, w);
      if (r) begin
        exp_f = 16'h0000;
        exp_v = 1'b0;
      end else begin
        exp_v = v;
        if (v) exp_f = model_f(w);
      end
      check_all($sformatf("rnd%0d", n), exp_f, exp_v);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
